// File: rtl/hazard_ctrl_mc_if.sv
// Hazard controller bus: decode/exe/mem hazard inputs and the forwarding,
// stall and flush outputs. The perf counters exist only when HAZ_PERF_EN is
// defined. The controller connects through the slave modport and the
// pipeline through the master modport.
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 4
);
    logic [REG_AW-1:0] rr1;
    logic [REG_AW-1:0] rr2;
    logic              forget_src2;
    logic [REG_AW-1:0] wr_exe;
    logic [REG_AW-1:0] wr_mem;
    logic              rfile_we_cexe;
    logic              rfile_we_cmem;
    logic              load_cexe;
    logic              load_cmem;
    logic              mc_start_cexe;
    logic              br_taken_cexe;
    logic [1:0]        dr1_src;
    logic [1:0]        dr2_src;
    logic              stall_fe_n;
    logic              stall_exe_n;
    logic              flush_dec;
    logic              flush_exe;
`ifdef HAZ_PERF_EN
    logic [15:0]       ld_stall_cnt;
    logic [15:0]       mc_stall_cnt;
`endif

    modport master (
`ifdef HAZ_PERF_EN
        input  ld_stall_cnt, mc_stall_cnt,
`endif
        output rr1, rr2, forget_src2, wr_exe, wr_mem,
        output rfile_we_cexe, rfile_we_cmem, load_cexe, load_cmem,
        output mc_start_cexe, br_taken_cexe,
        input  dr1_src, dr2_src, stall_fe_n, stall_exe_n, flush_dec, flush_exe
    );

    modport slave (
`ifdef HAZ_PERF_EN
        output ld_stall_cnt, mc_stall_cnt,
`endif
        input  rr1, rr2, forget_src2, wr_exe, wr_mem,
        input  rfile_we_cexe, rfile_we_cmem, load_cexe, load_cmem,
        input  mc_start_cexe, br_taken_cexe,
        output dr1_src, dr2_src, stall_fe_n, stall_exe_n, flush_dec, flush_exe
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard / forwarding controller for the 5-stage pipeline.
//
// Forwarding selects are combinational. A small FSM (IDLE, LD_STALL, MC_BUSY,
// LD_MASK) inserts load-use stalls and holds the pipeline for multi-cycle exe
// ops. Stall and flush outputs are Mealy, so a load-use hazard stalls in the
// cycle it is detected.
//
// Optional feature: define HAZ_PERF_EN to add the saturating
// ld_stall_cnt / mc_stall_cnt front-end stall cycle counters.
module hazard_ctrl_mc #(
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 1,
    parameter int MC_LAT   = 4,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_ctrl_mc_if.slave      hz
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MC_BUSY  = 2'd2,
        ST_LD_MASK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LD_CNT_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] MC_CNT_INIT = CNT_W'(MC_LAT - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_lu;
    logic [1:0]       w_dr1_src;
    logic [1:0]       w_dr2_src;
    logic             w_stall_fe_n;
    logic             w_stall_exe_n;
    logic             w_flush_dec;
    logic             w_flush_exe;

    // Forwarding select for one read port: the youngest producer (exe) wins,
    // a load in mem supplies its load data, otherwise read the register file.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rr,
        input logic              no_src,
        input logic [REG_AW-1:0] wr_exe,
        input logic              we_exe,
        input logic [REG_AW-1:0] wr_mem,
        input logic              we_mem,
        input logic              ld_mem
    );
        logic [1:0] sel;
        if (no_src) begin
            sel = 2'b10;
        end else if (we_exe && (rr == wr_exe)) begin
            sel = 2'b01;
        end else if (we_mem && (rr == wr_mem)) begin
            sel = ld_mem ? 2'b11 : 2'b00;
        end else begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // Load-use hazard: the decode instruction reads the destination of a load in exe.
    always_comb begin
        w_lu = hz.load_cexe &&
               ((hz.rr1 == hz.wr_exe) ||
                (!hz.forget_src2 && (hz.rr2 == hz.wr_exe)));
    end

    // Operand forwarding selects for both decode read ports, valid in every state.
    always_comb begin
        w_dr1_src = fwd_sel(hz.rr1, 1'b0, hz.wr_exe, hz.rfile_we_cexe,
                            hz.wr_mem, hz.rfile_we_cmem, hz.load_cmem);
        w_dr2_src = fwd_sel(hz.rr2, hz.forget_src2, hz.wr_exe, hz.rfile_we_cexe,
                            hz.wr_mem, hz.rfile_we_cmem, hz.load_cmem);
    end

    // State and stall counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. In LD_STALL the counter holds the stall cycles still
    // to serve including the current one, so the hazard cycle plus the
    // LD_STALL cycles add up to LOAD_LAT front-end stalls.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_LD_MASK: begin
                if (hz.br_taken_cexe) begin
                    w_state_nxt = ST_IDLE;
                end else if (hz.mc_start_cexe) begin
                    w_state_nxt = ST_MC_BUSY;
                    w_cnt_nxt   = MC_CNT_INIT;
                end else if ((r_state == ST_IDLE) && w_lu) begin
                    if (LOAD_LAT == 1) begin
                        w_state_nxt = ST_LD_MASK;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_LD_STALL;
                        w_cnt_nxt   = LD_CNT_INIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LD_STALL: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_LD_MASK;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            ST_MC_BUSY: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Stall/flush outputs; forced inactive while reset is asserted.
    always_comb begin
        w_stall_fe_n  = 1'b1;
        w_stall_exe_n = 1'b1;
        w_flush_dec   = 1'b0;
        w_flush_exe   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE, ST_LD_MASK: begin
                    if (hz.br_taken_cexe) begin
                        w_flush_dec = 1'b1;
                        w_flush_exe = 1'b1;
                    end else if (hz.mc_start_cexe) begin
                        w_stall_fe_n = 1'b1;
                    end else if ((r_state == ST_IDLE) && w_lu) begin
                        w_stall_fe_n = 1'b0;
                        w_flush_exe  = 1'b1;
                    end else begin
                        w_stall_fe_n = 1'b1;
                    end
                end
                ST_LD_STALL: begin
                    w_stall_fe_n = 1'b0;
                    w_flush_exe  = 1'b1;
                end
                ST_MC_BUSY: begin
                    w_stall_fe_n  = 1'b0;
                    w_stall_exe_n = 1'b0;
                end
                default: begin
                    w_stall_fe_n = 1'b1;
                end
            endcase
        end else begin
            w_stall_fe_n = 1'b1;
        end
    end

    assign hz.dr1_src     = w_dr1_src;
    assign hz.dr2_src     = w_dr2_src;
    assign hz.stall_fe_n  = w_stall_fe_n;
    assign hz.stall_exe_n = w_stall_exe_n;
    assign hz.flush_dec   = w_flush_dec;
    assign hz.flush_exe   = w_flush_exe;

`ifdef HAZ_PERF_EN
    logic        w_ld_stall;
    logic        w_mc_stall;
    logic [15:0] r_ld_stall_cnt;
    logic [15:0] r_mc_stall_cnt;

    // Attribute each front-end stall cycle to its cause.
    always_comb begin
        w_mc_stall = !w_stall_fe_n && (r_state == ST_MC_BUSY);
        w_ld_stall = !w_stall_fe_n && (r_state != ST_MC_BUSY);
    end

    // Saturating stall cycle counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_stall_cnt <= 16'h0000;
            r_mc_stall_cnt <= 16'h0000;
        end else begin
            if (w_ld_stall && (r_ld_stall_cnt != 16'hFFFF)) begin
                r_ld_stall_cnt <= r_ld_stall_cnt + 16'h0001;
            end else begin
                r_ld_stall_cnt <= r_ld_stall_cnt;
            end
            if (w_mc_stall && (r_mc_stall_cnt != 16'hFFFF)) begin
                r_mc_stall_cnt <= r_mc_stall_cnt + 16'h0001;
            end else begin
                r_mc_stall_cnt <= r_mc_stall_cnt;
            end
        end
    end

    assign hz.ld_stall_cnt = r_ld_stall_cnt;
    assign hz.mc_stall_cnt = r_mc_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: a table of forwarding vectors plus
// hand-written load-use, multi-cycle, branch and reset sequences. Two DUTs
// (LOAD_LAT=1 and LOAD_LAT=3) share the same stimulus.
module tb_hazard_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rr1, rr2, wr_exe, wr_mem;
    logic       forget_src2, rfile_we_cexe, rfile_we_cmem;
    logic       load_cexe, load_cmem, mc_start_cexe, br_taken_cexe;

    int n_chk = 0;
    int n_err = 0;

    hazard_ctrl_mc_if #(.REG_AW(4)) if_a ();
    hazard_ctrl_mc_if #(.REG_AW(4)) if_b ();

    assign if_a.rr1 = rr1;             assign if_b.rr1 = rr1;
    assign if_a.rr2 = rr2;             assign if_b.rr2 = rr2;
    assign if_a.forget_src2 = forget_src2;     assign if_b.forget_src2 = forget_src2;
    assign if_a.wr_exe = wr_exe;       assign if_b.wr_exe = wr_exe;
    assign if_a.wr_mem = wr_mem;       assign if_b.wr_mem = wr_mem;
    assign if_a.rfile_we_cexe = rfile_we_cexe; assign if_b.rfile_we_cexe = rfile_we_cexe;
    assign if_a.rfile_we_cmem = rfile_we_cmem; assign if_b.rfile_we_cmem = rfile_we_cmem;
    assign if_a.load_cexe = load_cexe; assign if_b.load_cexe = load_cexe;
    assign if_a.load_cmem = load_cmem; assign if_b.load_cmem = load_cmem;
    assign if_a.mc_start_cexe = mc_start_cexe; assign if_b.mc_start_cexe = mc_start_cexe;
    assign if_a.br_taken_cexe = br_taken_cexe; assign if_b.br_taken_cexe = br_taken_cexe;

    hazard_ctrl_mc #(.REG_AW(4), .LOAD_LAT(1), .MC_LAT(4), .CNT_W(4)) dut_a (
        .clk (clk), .rst (rst), .hz (if_a.slave)
    );
    hazard_ctrl_mc #(.REG_AW(4), .LOAD_LAT(3), .MC_LAT(4), .CNT_W(4)) dut_b (
        .clk (clk), .rst (rst), .hz (if_b.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rr1, rr2, wr_exe, wr_mem;
        logic       forget, we_exe, we_mem, ld_mem, br;
        logic [1:0] e_dr1, e_dr2;
        logic       e_flush;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rr1 = 4'd0; rr2 = 4'd0; wr_exe = 4'd0; wr_mem = 4'd0;
        forget_src2 = 1'b0; rfile_we_cexe = 1'b0; rfile_we_cmem = 1'b0;
        load_cexe = 1'b0; load_cmem = 1'b0; mc_start_cexe = 1'b0; br_taken_cexe = 1'b0;
    endtask

    task automatic set_lu();
        clr_in();
        load_cexe = 1'b1; wr_exe = 4'd5; rr2 = 4'd5; rfile_we_cexe = 1'b1; rr1 = 4'd0;
    endtask

    // Check all stall/flush outputs of DUT B.
    task automatic chk_b(input string nm, input logic fe_n, input logic exe_n,
                         input logic fd, input logic fe);
        chk({nm, ".stall_fe_n"},  {15'd0, if_b.stall_fe_n},  {15'd0, fe_n});
        chk({nm, ".stall_exe_n"}, {15'd0, if_b.stall_exe_n}, {15'd0, exe_n});
        chk({nm, ".flush_dec"},   {15'd0, if_b.flush_dec},   {15'd0, fd});
        chk({nm, ".flush_exe"},   {15'd0, if_b.flush_exe},   {15'd0, fe});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            rr1    rr2    wr_exe wr_mem fgt   we_e  we_m  ld_m  br    dr1    dr2    flush
        vecs[0] = '{4'd3,  4'd0,  4'd3,  4'd3,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0};
        vecs[1] = '{4'd3,  4'd0,  4'd3,  4'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 2'b10, 1'b0};
        vecs[2] = '{4'd3,  4'd0,  4'd3,  4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0};
        vecs[3] = '{4'd3,  4'd3,  4'd3,  4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0};
        vecs[4] = '{4'd7,  4'd3,  4'd3,  4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0};
        vecs[5] = '{4'd2,  4'd9,  4'd2,  4'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b11, 1'b0};
        vecs[6] = '{4'd4,  4'd1,  4'd1,  4'd4,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0};
        vecs[7] = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1};
        vecs[8] = '{4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0};

        // Reset with hazard and branch inputs active: outputs must stay quiet.
        rst = 1'b1;
        set_lu();
        br_taken_cexe = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a.stall_fe_n", {15'd0, if_a.stall_fe_n}, 16'd1);
        chk("rst.a.flush_exe",  {15'd0, if_a.flush_exe},  16'd0);
        chk_b("rst.b", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZ_PERF_EN
        chk("rst.ld_cnt", if_b.ld_stall_cnt, 16'd0);
        chk("rst.mc_cnt", if_b.mc_stall_cnt, 16'd0);
`endif
        cyc();
        rst = 1'b0;
        clr_in();

        // Forwarding table (no load in exe, so the FSM stays in IDLE).
        for (int i = 0; i < 9; i++) begin
            rr1 = vecs[i].rr1; rr2 = vecs[i].rr2;
            wr_exe = vecs[i].wr_exe; wr_mem = vecs[i].wr_mem;
            forget_src2 = vecs[i].forget;
            rfile_we_cexe = vecs[i].we_exe; rfile_we_cmem = vecs[i].we_mem;
            load_cmem = vecs[i].ld_mem; br_taken_cexe = vecs[i].br;
            #1;
            chk($sformatf("vec%0d.dr1", i), {14'd0, if_a.dr1_src}, {14'd0, vecs[i].e_dr1});
            chk($sformatf("vec%0d.dr2", i), {14'd0, if_a.dr2_src}, {14'd0, vecs[i].e_dr2});
            chk($sformatf("vec%0d.flush_dec", i), {15'd0, if_a.flush_dec}, {15'd0, vecs[i].e_flush});
            chk($sformatf("vec%0d.flush_exe", i), {15'd0, if_a.flush_exe}, {15'd0, vecs[i].e_flush});
            chk($sformatf("vec%0d.stall_fe_n", i), {15'd0, if_a.stall_fe_n}, 16'd1);
            cyc();
        end
        clr_in();
        cyc();

        // LOAD_LAT=1: one stall cycle, then a mask cycle forwarding load data.
        set_lu();
        #1;
        chk("ll1.hz.stall_fe_n", {15'd0, if_a.stall_fe_n}, 16'd0);
        chk("ll1.hz.flush_exe",  {15'd0, if_a.flush_exe},  16'd1);
        chk("ll1.hz.stall_exe_n", {15'd0, if_a.stall_exe_n}, 16'd1);
        cyc();
        rfile_we_cexe = 1'b0; wr_mem = 4'd5; rfile_we_cmem = 1'b1; load_cmem = 1'b1;
        #1;
        chk("ll1.mask.stall_fe_n", {15'd0, if_a.stall_fe_n}, 16'd1);
        chk("ll1.mask.flush_exe",  {15'd0, if_a.flush_exe},  16'd0);
        chk("ll1.mask.dr2",        {14'd0, if_a.dr2_src},    16'd3);
        cyc();
        #1;
        chk("ll1.idle.stall_fe_n", {15'd0, if_a.stall_fe_n}, 16'd0);
        clr_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // LOAD_LAT=3 with the hazard held: 3 stalls, 1 mask, repeat; then an MC op.
        set_lu();
        #1; chk_b("ll3.c0", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        #1; chk_b("ll3.c1", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        #1; chk_b("ll3.c2", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        #1; chk_b("ll3.mask", 1'b1, 1'b1, 1'b0, 1'b0); cyc();
        #1; chk_b("ll3.c4", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        #1; chk_b("ll3.c5", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        #1; chk_b("ll3.c6", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        #1; chk_b("ll3.mask2", 1'b1, 1'b1, 1'b0, 1'b0); cyc();
        clr_in();
        #1; chk_b("ll3.idle", 1'b1, 1'b1, 1'b0, 1'b0); cyc();
        mc_start_cexe = 1'b1;
        #1; chk_b("mc.start", 1'b1, 1'b1, 1'b0, 1'b0); cyc();
        mc_start_cexe = 1'b0;
        #1; chk_b("mc.b1", 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        br_taken_cexe = 1'b1;
        #1; chk_b("mc.b2_br", 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        br_taken_cexe = 1'b0;
        #1; chk_b("mc.b3", 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        #1; chk_b("mc.release", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZ_PERF_EN
        chk("perf.ld_cnt", if_b.ld_stall_cnt, 16'd6);
        chk("perf.mc_cnt", if_b.mc_stall_cnt, 16'd3);
`endif
        cyc();

        // Branch together with load-use: branch wins, no stall follows.
        set_lu();
        br_taken_cexe = 1'b1;
        #1; chk_b("br_lu", 1'b1, 1'b1, 1'b1, 1'b1); cyc();
        clr_in();
        #1; chk_b("br_lu.next", 1'b1, 1'b1, 1'b0, 1'b0); cyc();

        // Reset in the 1st LD_STALL cycle aborts the stall.
        set_lu();
        #1; chk_b("rs1.hz", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        rst = 1'b1;
        #1; chk_b("rs1.rst", 1'b1, 1'b1, 1'b0, 1'b0); cyc();
        rst = 1'b0;
        clr_in();
        #1; chk_b("rs1.after", 1'b1, 1'b1, 1'b0, 1'b0); cyc();

        // Reset in the 2nd LD_STALL cycle.
        set_lu();
        #1; chk_b("rs2.hz", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        #1; chk_b("rs2.st1", 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        rst = 1'b1;
        #1; chk_b("rs2.rst", 1'b1, 1'b1, 1'b0, 1'b0); cyc();
        rst = 1'b0;
        clr_in();
        #1; chk_b("rs2.after", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZ_PERF_EN
        chk("rs2.ld_cnt", if_b.ld_stall_cnt, 16'd0);
`endif
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised next-generation hazard/forwarding controller for the 5-stage RISC pipeline (dec, exe, mem, wb).
- Generates operand-forwarding selects for both decode read ports.
- Stalls on load-use hazards for a configurable load latency and holds the pipeline while a multi-cycle exe op (mul/div) completes.
- Flushes wrong-path instructions on taken branches.

Parameters:
- REG_AW, 4: register-address width (rr*, wr_* ports).
- LOAD_LAT, 1: stall cycles inserted on a load-use hazard (1..15).
- MC_LAT, 4: total exe cycles of a multi-cycle op (2..15); front end holds for MC_LAT-1 cycles.
- CNT_W, 4: width of the internal stall counter; must satisfy 2^CNT_W > max(LOAD_LAT, MC_LAT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rr1  in  REG_AW  dec source reg 1.
- rr2  in  REG_AW  dec source reg 2.
- forget_src2  in  1  dec instr has no src2 (immediate); rr2 ignored.
- wr_exe  in  REG_AW  exe dest reg.
- wr_mem  in  REG_AW  mem dest reg.
- rfile_we_cexe  in  1  exe instr writes the register file.
- rfile_we_cmem  in  1  mem instr writes the register file.
- load_cexe  in  1  exe instr is a load.
- load_cmem  in  1  mem instr is a load.
- mc_start_cexe  in  1  multi-cycle op in exe, first cycle.
- br_taken_cexe  in  1  branch resolved taken in exe.
- dr1_src  out  2  fwd select for port 1: 01 = exe ALU, 00 = mem ALU, 11 = mem load data, 10 = regfile.
- dr2_src  out  2  same encoding for port 2.
- stall_fe_n  out  1  active-low hold of pc/ir/dec.
- stall_exe_n  out  1  active-low hold of the exe stage.
- flush_dec  out  1  active-high bubble into dec.
- flush_exe  out  1  active-high bubble into exe.

Behaviour:
- Forwarding is combinational and applies in every state.
  - Port 1: exe match (rr1==wr_exe and rfile_we_cexe) gives 01.
  - Otherwise mem match gives 11 when load_cmem, else 00.
  - Otherwise 10.
  - Exe match has priority over mem match.
  - Port 2 uses the same rules, but with forget_src2=1 it is forced to 10.
- Load-use detect: lu = load_cexe and (rr1==wr_exe, or rr2==wr_exe with forget_src2=0).
- Registered FSM, states IDLE, LD_STALL, MC_BUSY, LD_MASK; counter cnt.
  - IDLE:
    - br_taken_cexe has highest priority: flush_dec=flush_exe=1, no stall, stay IDLE.
    - Else mc_start_cexe: go to MC_BUSY, cnt=MC_LAT-2.
    - Else lu: go to LD_STALL, cnt=LOAD_LAT-1.
    - lu raises stall_fe_n=0 and flush_exe=1 in the same (Mealy) cycle.
  - LD_STALL: stall_fe_n=0, flush_exe=1. cnt decrements each cycle; at cnt==0 go to LD_MASK. With LOAD_LAT=1 the hazard cycle itself is the only stall, and the FSM goes from IDLE straight to LD_MASK.
  - LD_MASK: one cycle, lu is ignored (the held instruction now sees its producer in mem via 11), no stall. Next state is IDLE; branch and mc rules as in IDLE still apply.
  - MC_BUSY: stall_fe_n=0, stall_exe_n=0, flush_exe=0. br_taken_cexe is ignored (exe holds a non-branch). cnt decrements; at cnt==0 go to IDLE, with all stalls released in the following cycle.
- Simultaneous events:
  - br_taken with lu: branch wins, no stall.
  - mc_start with lu: go to MC_BUSY; lu is re-evaluated after release.
- Default outputs when none of the above apply: stall_*_n=1, flush_*=0.
- Reset (synchronous): state=IDLE, cnt=0.
  - stall_fe_n=stall_exe_n=1 and flush_dec=flush_exe=0 while rst=1, regardless of inputs.
  - Reset mid-stall aborts the stall in the next cycle.

Optional Feature:
- Macro HAZ_PERF_EN.
- When defined, adds outputs ld_stall_cnt[15:0] and mc_stall_cnt[15:0]:
  - Saturating counters that count cycles with stall_fe_n=0, attributed to the load or multi-cycle cause.
  - Cleared by rst; they hold at 16'hFFFF.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Port-1 exe match: rr1=3, wr_exe=3, rfile_we_cexe=1, wr_mem=3, load_cmem=1 -> dr1_src=01. Drop rfile_we_cexe -> 11. Drop load_cmem -> 00. forget_src2=1 with rr2=3 -> dr2_src=10.
- LOAD_LAT=1: load_cexe=1, wr_exe=5, rr2=5 -> stall_fe_n=0 and flush_exe=1 for exactly 1 cycle, then LD_MASK with no stall; dr2_src=11 in the mask cycle.
- LOAD_LAT=3: same stimulus held -> 3 consecutive stall cycles, then 1 mask cycle, then IDLE.
- MC_LAT=4: mc_start_cexe pulse -> stall_fe_n=stall_exe_n=0 for 3 cycles, flush_exe=0. A br_taken_cexe asserted during those cycles -> no flush.
- br_taken_cexe with lu in the same cycle -> flush_dec=flush_exe=1 and stall_fe_n=1. Then rst asserted in the 2nd LD_STALL cycle of a LOAD_LAT=3 run -> all stalls deasserted the next cycle.
- HAZ_PERF_EN: two LOAD_LAT=3 hazards plus one MC_LAT=4 op -> ld_stall_cnt=6, mc_stall_cnt=3.
